leaf_bft_rx_demux: RTL and testbench

Ingress stage of a leaf interface, directly downstream of the BFT leaf port. Consumes the 49-bit din_leaf_bft2interface flit stream and filters on the leaf address. Demultiplexes payloads by port id into per-port show-ahead FIFOs feeding the operator's valid/ready input streams. Returns flow-control credits to the BFT as 49-bit packets on dout_leaf_interface2bft.

---
 rtl/leaf_pkt_pkg.sv | 36 +++
 rtl/leaf_rx_fifo.sv | 41 ++++
 rtl/leaf_bft_rx_demux.sv | 144 ++++++++++++++
 tb/tb_leaf_bft_rx_demux.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/leaf_pkt_pkg.sv
// Shared definitions for the leaf interface ingress path.
// Holds the BFT flit layout (field positions), the credit FSM state type and
// a helper that assembles a credit packet from its fields.
package leaf_pkt_pkg;

    localparam int PKT_W       = 49;
    localparam int PAYLOAD_W   = 32;

    localparam int VALID_BIT   = 48;
    localparam int DEST_MSB    = 47;
    localparam int DEST_LSB    = 43;
    localparam int PORT_MSB    = 42;
    localparam int PORT_LSB    = 39;
    // Meta on ingress flits, credit count on credit packets.
    localparam int META_MSB    = 38;
    localparam int META_LSB    = 32;
    localparam int PAYLOAD_MSB = 31;
    localparam int PAYLOAD_LSB = 0;

    typedef enum logic {IDLE, SEND} credit_state_t;

    function automatic logic [PKT_W-1:0] build_credit_pkt(
        input logic [4:0] dest,
        input logic [3:0] port,
        input logic [6:0] count
    );
        logic [PKT_W-1:0] pkt;
        pkt                     = '0;
        pkt[VALID_BIT]          = 1'b1;
        pkt[DEST_MSB:DEST_LSB]  = dest;
        pkt[PORT_MSB:PORT_LSB]  = port;
        pkt[META_MSB:META_LSB]  = count;
        return pkt;
    endfunction

endpackage

// File: rtl/leaf_rx_fifo.sv
// Synchronous show-ahead FIFO: rd_data always presents the head entry while
// empty is low. A push while full and a pop while empty are ignored.
// Ports: clk/rst, push/wr_data, pop, rd_data, full, empty.
module leaf_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]  wr_ptr, rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/leaf_bft_rx_demux.sv
// Leaf interface ingress: registers BFT flits, keeps those addressed to this
// leaf, steers each payload by port id into a per-port show-ahead FIFO that
// feeds a valid/ready stream, and returns credits to the BFT.
// Ports: clk_400/reset_400; ap_start (sticky start), resend (flush credits);
// din_leaf_bft2interface (flit in); dout_leaf_interface2bft (credit out);
// dout_valid/dout_data/dout_ready (per-port streams); drop_count.
module leaf_bft_rx_demux
    import leaf_pkt_pkg::*;
#(
    parameter logic [4:0] LEAF_ADDR        = 5'd2,
    parameter int         NUM_PORTS        = 4,
    parameter int         FIFO_DEPTH       = 16,
    parameter int         CREDIT_BATCH     = 4,
    parameter logic [4:0] CREDIT_DEST_LEAF = 5'd0
) (
    input  logic                           clk_400,
    input  logic                           reset_400,
    input  logic                           ap_start,
    input  logic                           resend,
    input  logic [PKT_W-1:0]               din_leaf_bft2interface,
    output logic [PKT_W-1:0]               dout_leaf_interface2bft,
    output logic [NUM_PORTS-1:0]           dout_valid,
    output logic [NUM_PORTS*PAYLOAD_W-1:0] dout_data,
    input  logic [NUM_PORTS-1:0]           dout_ready,
    output logic [15:0]                    drop_count
);
    logic [PKT_W-1:0]     din_q;
    logic                 started;
    logic [NUM_PORTS-1:0] port_hit, push, pop, full, empty;
    logic [NUM_PORTS-1:0][PAYLOAD_W-1:0] rdata;
    logic                 accept, drop;

    wire       flit_vld  = din_q[VALID_BIT];
    wire [4:0] flit_dest = din_q[DEST_MSB:DEST_LSB];
    wire [3:0] flit_port = din_q[PORT_MSB:PORT_LSB];

    // Full is sampled before this cycle's pop, so a full FIFO drops the flit.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) port_hit[p] = (flit_port == 4'(p));
        accept = flit_vld && (flit_dest == LEAF_ADDR) && (int'(flit_port) < NUM_PORTS)
                 && !(|(port_hit & full));
        drop   = flit_vld && !accept;
        push   = accept ? port_hit : '0;
    end

    assign dout_valid = {NUM_PORTS{started}} & ~empty;
    assign pop        = dout_valid & dout_ready;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        leaf_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(PAYLOAD_W)) u_fifo (
            .clk     (clk_400),
            .rst     (reset_400),
            .push    (push[g]),
            .wr_data (din_q[PAYLOAD_MSB:PAYLOAD_LSB]),
            .pop     (pop[g]),
            .rd_data (rdata[g]),
            .full    (full[g]),
            .empty   (empty[g])
        );
        assign dout_data[g*PAYLOAD_W +: PAYLOAD_W] = dout_valid[g] ? rdata[g] : '0;
    end

    always_ff @(posedge clk_400 or posedge reset_400) begin
        if (reset_400) begin
            din_q      <= '0;
            started    <= 1'b0;
            drop_count <= '0;
        end else begin
            din_q <= din_leaf_bft2interface;
            if (ap_start) started <= 1'b1;
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    // ---------------- credit return ----------------
    credit_state_t state, state_nxt;
    logic [3:0]    sel, sel_nxt, rr_ptr;
    logic [6:0]    snap, snap_nxt;
    logic [6:0]    pending     [NUM_PORTS];
    logic [6:0]    pending_nxt [NUM_PORTS];
    logic          flush, all_zero;

    always_comb begin
        logic found;
        int   idx;
        found     = 1'b0;
        idx       = 0;
        state_nxt = state;
        sel_nxt   = sel;
        snap_nxt  = snap;
        all_zero  = 1'b1;
        dout_leaf_interface2bft = '0;
        for (int p = 0; p < NUM_PORTS; p++) all_zero &= (pending[p] == 7'd0);
        case (state)
            IDLE: begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    idx = (int'(rr_ptr) + i) % NUM_PORTS;
                    if (!found && (int'(pending[idx]) >= CREDIT_BATCH ||
                                   (flush && pending[idx] != 7'd0))) begin
                        found    = 1'b1;
                        sel_nxt  = 4'(idx);
                        snap_nxt = pending[idx];
                    end
                end
                if (found) state_nxt = SEND;
            end
            SEND: begin
                dout_leaf_interface2bft = build_credit_pkt(CREDIT_DEST_LEAF, sel, snap);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pops landing during SEND stay pending; only the snapshot is retired.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            logic [7:0] nxt;
            nxt = {1'b0, pending[p]} + {7'd0, pop[p]};
            if (state == SEND && sel == 4'(p)) nxt = nxt - {1'b0, snap};
            pending_nxt[p] = (nxt > 8'd127) ? 7'd127 : nxt[6:0];
        end
    end

    always_ff @(posedge clk_400 or posedge reset_400) begin
        if (reset_400) begin
            state  <= IDLE;
            sel    <= '0;
            snap   <= '0;
            rr_ptr <= '0;
            flush  <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) pending[p] <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            snap  <= snap_nxt;
            if (state == SEND) rr_ptr <= 4'((int'(sel) + 1) % NUM_PORTS);
            if (resend)                        flush <= 1'b1;
            else if (state == IDLE && all_zero) flush <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) pending[p] <= pending_nxt[p];
        end
    end

endmodule

// File: tb/tb_leaf_bft_rx_demux.sv
module tb_leaf_bft_rx_demux;
    logic         clk_400 = 1'b0;
    logic         reset_400;
    logic         ap_start, resend;
    logic [48:0]  din;
    logic [48:0]  dout_pkt;
    logic [3:0]   dout_valid, dout_ready;
    logic [127:0] dout_data;
    logic [15:0]  drop_count;

    int n_cmp = 0, n_bad = 0;
    int pkt_cnt = 0, vld_cnt = 0;
    logic [48:0] last_pkt = '0;

    leaf_bft_rx_demux dut (
        .clk_400                 (clk_400),
        .reset_400               (reset_400),
        .ap_start                (ap_start),
        .resend                  (resend),
        .din_leaf_bft2interface  (din),
        .dout_leaf_interface2bft (dout_pkt),
        .dout_valid              (dout_valid),
        .dout_data               (dout_data),
        .dout_ready              (dout_ready),
        .drop_count              (drop_count)
    );

    always #5 clk_400 = ~clk_400;

    // Credit packet and stream-valid monitor, sampled away from the edge.
    always @(negedge clk_400) begin
        if (dout_pkt[48]) begin
            pkt_cnt  <= pkt_cnt + 1;
            last_pkt <= dout_pkt;
        end
        if (|dout_valid) vld_cnt <= vld_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_400); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [48:0] flit(input logic [4:0] dest, input logic [3:0] port,
                                         input logic [31:0] pl);
        return {1'b1, dest, port, 7'd0, pl};
    endfunction

    task automatic do_reset();
        reset_400 = 1'b1; din = '0; ap_start = 1'b0; resend = 1'b0; dout_ready = 4'hF;
        idle(2);
        reset_400 = 1'b0;
        tick();
    endtask

    task automatic start();
        ap_start = 1'b1; tick(); ap_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        // ---- reset state ----
        reset_400 = 1'b1; din = '0; ap_start = 1'b0; resend = 1'b0; dout_ready = 4'hF;
        #12;
        chk("rst_valid", dout_valid, 0);
        chk("rst_data", dout_data, 0);
        chk("rst_pkt", dout_pkt, 0);
        chk("rst_drop", drop_count, 0);
        do_reset();

        // ---- port 1 delivery, two-cycle latency, single cycle valid ----
        ap_start = 1'b1; din = flit(5'd2, 4'd1, 32'hDEADBEEF);
        tick();
        ap_start = 1'b0; din = '0;
        @(negedge clk_400);
        chk("lat_early", dout_valid, 4'h0);
        tick();
        @(negedge clk_400);
        chk("lat_valid", dout_valid, 4'b0010);
        chk("lat_data", dout_data[63:32], 32'hDEADBEEF);
        tick();
        @(negedge clk_400);
        chk("lat_once", dout_valid, 4'h0);
        base = pkt_cnt;
        idle(10);
        chk("p1_nocredit", pkt_cnt - base, 0);
        resend = 1'b1; tick(); resend = 1'b0;
        idle(6);
        chk("p1_flush_n", pkt_cnt - base, 1);
        chk("p1_flush_pkt", last_pkt, 49'h1_0081_0000_0000);

        // ---- batch credit on port 0 ----
        do_reset(); start();
        base = pkt_cnt;
        for (int i = 0; i < 4; i++) begin
            din = flit(5'd2, 4'd0, 32'(i)); tick();
        end
        din = '0;
        idle(10);
        chk("batch_n", pkt_cnt - base, 1);
        chk("batch_pkt", last_pkt, 49'h1_0004_0000_0000);
        resend = 1'b1; tick(); resend = 1'b0;
        idle(6);
        chk("batch_zero", pkt_cnt - base, 1);

        // ---- address and port filtering ----
        do_reset(); start();
        base = vld_cnt;
        din = flit(5'd3, 4'd0, 32'h11); tick();
        din = flit(5'd2, 4'd5, 32'h22); tick();
        din = '0;
        chk("filt_dest", drop_count, 16'd1);
        tick();
        chk("filt_port", drop_count, 16'd2);
        idle(4);
        chk("filt_novalid", vld_cnt - base, 0);

        // ---- overflow on port 2 ----
        do_reset(); start();
        dout_ready = 4'b1011;
        for (int i = 0; i < 17; i++) begin
            din = flit(5'd2, 4'd2, 32'(i)); tick();
        end
        din = '0;
        idle(4);
        chk("ovf_drop", drop_count, 16'd1);
        dout_ready = 4'hF;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_400);
            chk("ovf_valid", dout_valid[2], 1'b1);
            chk("ovf_data", dout_data[95:64], 32'(i));
            tick();
        end
        @(negedge clk_400);
        chk("ovf_empty", dout_valid, 4'h0);

        // ---- resend flush on port 3 ----
        do_reset(); start();
        base = pkt_cnt;
        din = flit(5'd2, 4'd3, 32'hA); tick();
        din = flit(5'd2, 4'd3, 32'hB); tick();
        din = '0;
        idle(10);
        chk("rs_none", pkt_cnt - base, 0);
        resend = 1'b1; tick(); resend = 1'b0;
        idle(6);
        chk("rs_one", pkt_cnt - base, 1);
        chk("rs_pkt", last_pkt, 49'h1_0182_0000_0000);
        idle(10);
        chk("rs_quiet", pkt_cnt - base, 1);

        // ---- start gating and mid-drain reset ----
        do_reset();
        for (int i = 0; i < 3; i++) begin
            din = flit(5'd2, 4'd0, 32'hA0 + 32'(i)); tick();
        end
        din = '0;
        idle(4);
        @(negedge clk_400);
        chk("gate_off", dout_valid, 4'h0);
        tick();
        ap_start = 1'b1; tick(); ap_start = 1'b0;
        @(negedge clk_400);
        chk("gate_on", dout_valid, 4'b0001);
        chk("gate_data", dout_data[31:0], 32'hA0);
        tick();
        reset_400 = 1'b1;
        #1;
        chk("mrst_valid", dout_valid, 0);
        chk("mrst_data", dout_data, 0);
        chk("mrst_pkt", dout_pkt, 0);
        chk("mrst_drop", drop_count, 0);
        idle(2);
        reset_400 = 1'b0;
        tick();
        start();
        tick();
        @(negedge clk_400);
        chk("mrst_empty", dout_valid, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
